// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        s_WAIT_IDLE = 3'd0,
        s_IDLE      = 3'd1,
        s_START     = 3'd2,
        s_DATA      = 3'd3,
        s_PARITY    = 3'd4,
        s_STOP      = 3'd5,
        s_DONE      = 3'd6
    } uart_rx_state_t;

    // Legal parameter ranges for uart_rx_frame, evaluated at elaboration.
    function automatic bit rx_params_ok(input int cpb, input int data_bits,
                                        input int parity_mode, input int stop_bits);
        return (cpb >= 4) && (data_bits >= 5) && (data_bits <= 64) &&
               (parity_mode >= PARITY_NONE) && (parity_mode <= PARITY_ODD) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit with a selectable reset level.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; the reset level matches the idle level of the source.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values, forming a true 2-stage chain.
            r_meta <= i_Async;
            r_sync <= r_meta;
        end
    end

    assign o_Sync = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable width, optional parity, 1 or 2 stop bits,
// parity/framing/break reporting, one word per frame with a single-cycle strobe.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 34,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Word,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    if (!rx_params_ok(CLKS_PER_BIT, DATA_BITS, PARITY_MODE, STOP_BITS)) begin : g_bad_params
        $error("uart_rx_frame: parameter out of range");
    end

    localparam int             CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int             IDX_W   = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic           PAR_ODD = (PARITY_MODE == PARITY_ODD);

    logic                 w_rx;
    logic                 w_mid_tick;
    logic                 w_bit_tick;
    uart_rx_state_t       w_next_state;

    uart_rx_state_t       r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_par_err_acc;
    logic                 r_frame_acc;
    logic                 r_zero;
    logic [1:0]           r_sync_primed;
    logic                 r_rx_dv;
    logic [DATA_BITS-1:0] r_word;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_break;
    logic                 r_busy;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Async   (i_Rx_Serial),
        .o_Sync    (w_rx)
    );

    // Next-state decode from the current state, bit counter and synchronized line.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_mid_tick   = (r_cnt == CNT_MID);
        w_bit_tick   = (r_cnt == CNT_LAST);
        unique case (r_state)
            s_WAIT_IDLE: if (r_sync_primed[1] && w_rx) w_next_state = s_IDLE;
            s_IDLE:      if (!w_rx) w_next_state = s_START;
            s_START:     if (w_mid_tick) w_next_state = w_rx ? s_IDLE : s_DATA;
            s_DATA:      if (w_bit_tick && (r_idx == IDX_LAST_DATA))
                             w_next_state = (PARITY_MODE != PARITY_NONE) ? s_PARITY : s_STOP;
            s_PARITY:    if (w_bit_tick) w_next_state = s_STOP;
            s_STOP:      if (w_bit_tick && (r_idx == IDX_LAST_STOP)) w_next_state = s_DONE;
            s_DONE:      w_next_state = r_frame_acc ? s_WAIT_IDLE : s_IDLE;
            default:     w_next_state = s_WAIT_IDLE;
        endcase
    end

    // State register plus the receive datapath: counters, shift register, error accumulators, outputs.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state       <= s_WAIT_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_par_err_acc <= 1'b0;
            r_frame_acc   <= 1'b0;
            r_zero        <= 1'b1;
            r_sync_primed <= 2'b00;
            r_rx_dv       <= 1'b0;
            r_word        <= '0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_break       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_busy        <= (w_next_state != s_IDLE);
            r_rx_dv       <= 1'b0;
            // The synchronizer resets to idle-high; ignore its output until real line
            // samples have flushed through, so a reset mid-frame cannot fake an idle line.
            r_sync_primed <= {r_sync_primed[0], 1'b1};
            unique case (r_state)
                s_IDLE: begin
                    r_cnt         <= '0;
                    r_idx         <= '0;
                    r_par         <= 1'b0;
                    r_par_err_acc <= 1'b0;
                    r_frame_acc   <= 1'b0;
                    r_zero        <= 1'b1;
                end
                s_START: r_cnt <= w_mid_tick ? '0 : r_cnt + CNT_W'(1);
                s_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_rx;
                        r_zero  <= r_zero & ~w_rx;
                        r_idx   <= (r_idx == IDX_LAST_DATA) ? '0 : r_idx + IDX_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                s_PARITY: begin
                    if (w_bit_tick) begin
                        r_cnt         <= '0;
                        r_par_err_acc <= w_rx ^ r_par ^ PAR_ODD;
                        r_zero        <= r_zero & ~w_rx;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                s_STOP: begin
                    if (w_bit_tick) begin
                        r_cnt       <= '0;
                        r_idx       <= r_idx + IDX_W'(1);
                        r_frame_acc <= r_frame_acc | ~w_rx;
                        if (r_idx == '0) r_zero <= r_zero & ~w_rx;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                s_DONE: begin
                    r_rx_dv      <= 1'b1;
                    r_word       <= r_shift;
                    r_parity_err <= r_par_err_acc;
                    r_frame_err  <= r_frame_acc;
                    r_break      <= r_zero;
                end
                default: ;
            endcase
        end
    end

    assign o_Rx_DV      = r_rx_dv;
    assign o_Rx_Word    = r_word;
    assign o_Parity_Err = r_parity_err;
    assign o_Frame_Err  = r_frame_err;
    assign o_Break      = r_break;
    assign o_Busy       = r_busy;

endmodule
